// File: rtl/mem_access_delay_fifo.sv
// Delay FIFO for memory accesses. Each entry carries an address, its enqueue
// time and a release time. The head is popped only once its release time is
// reached, and entries always leave in order.
module mem_access_delay_fifo #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned TIME_W   = 16,
    parameter int unsigned DELAY_W  = 10,
    parameter int unsigned AF_LEVEL = DEPTH - 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall_i,
    input  logic                      flush_i,
    input  logic                      i,
    input  logic [ADDR_W-1:0]         RAM_Addr_i,
    input  logic [DELAY_W-1:0]        Delay,
    input  logic [TIME_W-1:0]         count,
    input  logic                      o,
    output logic [ADDR_W-1:0]         RAM_Addr_o,
    output logic [TIME_W-1:0]         HeadInTime,
    output logic [TIME_W-1:0]         HeadOutTime,
    output logic                      ready_o,
    output logic                      empty,
    output logic                      full,
    output logic                      almost_full,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic                      early_pop
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [TIME_W-1:0] r_mem_in   [DEPTH];
    logic [TIME_W-1:0] r_mem_out  [DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              r_overflow;
    logic              r_early_pop;
    logic              r_armed;
    logic [ADDR_W-1:0] r_head_addr;
    logic [TIME_W-1:0] r_head_in;
    logic [TIME_W-1:0] r_head_out;

    logic [TIME_W-1:0] w_out_time;
    logic [TIME_W-1:0] w_age;
    logic              w_empty;
    logic              w_full;
    logic              w_ready;
    logic              w_go;
    logic              w_pop;
    logic              w_push;
    logic [PTR_W-1:0]  w_rd_nxt;
    logic [LVL_W-1:0]  w_lvl_after_pop;
    logic [LVL_W-1:0]  w_lvl_nxt;
    logic [ADDR_W-1:0] w_head_addr_nxt;
    logic [TIME_W-1:0] w_head_in_nxt;
    logic [TIME_W-1:0] w_head_out_nxt;

    // Occupancy, wrap-safe release compare and push/pop acceptance
    always_comb begin
        w_out_time      = count + TIME_W'(Delay);
        w_age           = count - r_head_out;
        w_empty         = (r_level == LVL_W'(0));
        w_full          = (r_level == LVL_W'(DEPTH));
        w_ready         = !w_empty && !w_age[TIME_W-1];
        w_go            = r_armed && !stall_i && !flush_i;
        w_pop           = w_go && o && w_ready;
        w_push          = w_go && i && (!w_full || w_pop);
        w_rd_nxt        = r_rd_ptr + PTR_W'(w_pop);
        w_lvl_after_pop = r_level - LVL_W'(w_pop);
        w_lvl_nxt       = w_lvl_after_pop + LVL_W'(w_push);
    end

    // Next head: bypass the incoming entry when it becomes head, else read storage
    always_comb begin
        w_head_addr_nxt = r_head_addr;
        w_head_in_nxt   = r_head_in;
        w_head_out_nxt  = r_head_out;
        if ((w_push || w_pop) && (w_lvl_nxt != LVL_W'(0))) begin
            if (w_lvl_after_pop == LVL_W'(0)) begin
                w_head_addr_nxt = RAM_Addr_i;
                w_head_in_nxt   = count;
                w_head_out_nxt  = w_out_time;
            end else begin
                w_head_addr_nxt = r_mem_addr[w_rd_nxt];
                w_head_in_nxt   = r_mem_in[w_rd_nxt];
                w_head_out_nxt  = r_mem_out[w_rd_nxt];
            end
        end
    end

    // Entry storage; contents are only read once written, so no reset needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= RAM_Addr_i;
            r_mem_in[r_wr_ptr]   <= count;
            r_mem_out[r_wr_ptr]  <= w_out_time;
        end
    end

    // Pointers, level, sticky error flags and registered head view
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_early_pop <= 1'b0;
            r_armed     <= 1'b0;
            r_head_addr <= '0;
            r_head_in   <= '0;
            r_head_out  <= '0;
        end else begin
            r_armed <= 1'b1;
            if (flush_i) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_level     <= '0;
                r_overflow  <= 1'b0;
                r_early_pop <= 1'b0;
            end else begin
                r_wr_ptr    <= r_wr_ptr + PTR_W'(w_push);
                r_rd_ptr    <= w_rd_nxt;
                r_level     <= w_lvl_nxt;
                r_head_addr <= w_head_addr_nxt;
                r_head_in   <= w_head_in_nxt;
                r_head_out  <= w_head_out_nxt;
                if (w_go && i && w_full && !w_pop) begin
                    r_overflow <= 1'b1;
                end
                if (w_go && o && !w_empty && !w_ready) begin
                    r_early_pop <= 1'b1;
                end
            end
        end
    end

    assign RAM_Addr_o  = r_head_addr;
    assign HeadInTime  = r_head_in;
    assign HeadOutTime = r_head_out;
    assign ready_o     = w_ready;
    assign empty       = w_empty;
    assign full        = w_full;
    assign almost_full = (r_level >= LVL_W'(AF_LEVEL));
    assign level       = r_level;
    assign overflow    = r_overflow;
    assign early_pop   = r_early_pop;

endmodule

// File: tb/tb_mem_access_delay_fifo.sv
// Bench for mem_access_delay_fifo: directed scenarios plus random traffic,
// all checked against a queue-based reference model.
module tb_mem_access_delay_fifo;

    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIME_W  = 16;
    localparam int unsigned DELAY_W = 10;
    localparam int unsigned AF      = DEPTH - 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                stall_i;
    logic                flush_i;
    logic                i;
    logic [ADDR_W-1:0]   RAM_Addr_i;
    logic [DELAY_W-1:0]  Delay;
    logic [TIME_W-1:0]   count;
    logic                o;
    logic [ADDR_W-1:0]   RAM_Addr_o;
    logic [TIME_W-1:0]   HeadInTime;
    logic [TIME_W-1:0]   HeadOutTime;
    logic                ready_o;
    logic                empty;
    logic                full;
    logic                almost_full;
    logic [2:0]          level;
    logic                overflow;
    logic                early_pop;

    mem_access_delay_fifo #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIME_W(TIME_W), .DELAY_W(DELAY_W), .AF_LEVEL(AF)
    ) dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .i(i),
        .RAM_Addr_i(RAM_Addr_i), .Delay(Delay), .count(count), .o(o),
        .RAM_Addr_o(RAM_Addr_o), .HeadInTime(HeadInTime), .HeadOutTime(HeadOutTime),
        .ready_o(ready_o), .empty(empty), .full(full), .almost_full(almost_full),
        .level(level), .overflow(overflow), .early_pop(early_pop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [TIME_W-1:0] tin;
        logic [TIME_W-1:0] tout;
    } ent_t;

    ent_t              q[$];
    logic [ADDR_W-1:0] m_addr;
    logic [TIME_W-1:0] m_in;
    logic [TIME_W-1:0] m_out;
    bit                m_ovf;
    bit                m_early;
    int                n_checks = 0;
    int                n_errors = 0;
    logic [TIME_W-1:0] cur_cnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Head is released once count has reached its release time (mod 2^16, half-range window)
    function automatic bit m_ready();
        logic [TIME_W-1:0] d;
        if (q.size() == 0) return 1'b0;
        d = count - q[0].tout;
        return (d < 16'h8000);
    endfunction

    task automatic model_clear();
        q.delete();
        m_ovf   = 1'b0;
        m_early = 1'b0;
        m_addr  = '0;
        m_in    = '0;
        m_out   = '0;
    endtask

    task automatic check_all();
        int sz;
        sz = q.size();
        check_val("level",       32'(level),       32'(sz));
        check_val("empty",       32'(empty),       32'(sz == 0));
        check_val("full",        32'(full),        32'(sz == DEPTH));
        check_val("almost_full", 32'(almost_full), 32'(sz >= AF));
        check_val("ready_o",     32'(ready_o),     32'(m_ready()));
        check_val("overflow",    32'(overflow),    32'(m_ovf));
        check_val("early_pop",   32'(early_pop),   32'(m_early));
        check_val("head_addr",   32'(RAM_Addr_o),  32'(m_addr));
        check_val("head_in",     32'(HeadInTime),  32'(m_in));
        check_val("head_out",    32'(HeadOutTime), 32'(m_out));
    endtask

    // Apply the current inputs to the model as the coming rising edge would
    task automatic model_step();
        bit   rdy;
        bit   pop_ok;
        bit   push_ok;
        bit   is_full;
        bit   is_empty;
        ent_t e;
        is_empty = (q.size() == 0);
        is_full  = (q.size() == DEPTH);
        rdy      = m_ready();
        if (flush_i) begin
            q.delete();
            m_ovf   = 1'b0;
            m_early = 1'b0;
        end else if (!stall_i) begin
            pop_ok  = o && rdy;
            push_ok = i && (!is_full || pop_ok);
            if (i && is_full && !pop_ok) m_ovf = 1'b1;
            if (o && !is_empty && !rdy) m_early = 1'b1;
            if (pop_ok) void'(q.pop_front());
            if (push_ok) begin
                e.addr = RAM_Addr_i;
                e.tin  = count;
                e.tout = count + 16'(Delay);
                q.push_back(e);
            end
            if (q.size() != 0) begin
                m_addr = q[0].addr;
                m_in   = q[0].tin;
                m_out  = q[0].tout;
            end
        end
    endtask

    task automatic cyc(input bit ii, input logic [ADDR_W-1:0] a, input logic [DELAY_W-1:0] d,
                       input bit oo, input bit st, input bit fl, input logic [TIME_W-1:0] cnt);
        @(negedge clk);
        i          = ii;
        RAM_Addr_i = a;
        Delay      = d;
        o          = oo;
        stall_i    = st;
        flush_i    = fl;
        count      = cnt;
        #1;
        check_all();
        model_step();
    endtask

    task automatic idle(input logic [TIME_W-1:0] cnt);
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, cnt);
    endtask

    // Asynchronous reset away from the clock edge; outputs must clear without an edge
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset   = 1'b0;
        i       = 1'b0;
        o       = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        #1;
        check_val("rst_level", 32'(level),      32'd0);
        check_val("rst_empty", 32'(empty),      32'd1);
        check_val("rst_full",  32'(full),       32'd0);
        check_val("rst_ready", 32'(ready_o),    32'd0);
        check_val("rst_addr",  32'(RAM_Addr_o), 32'd0);
        check_val("rst_ovf",   32'(overflow),   32'd0);
        model_clear();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; i = 1'b0; o = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        RAM_Addr_i = '0; Delay = '0; count = '0;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        check_val("init_level",  32'(level),       32'd0);
        check_val("init_empty",  32'(empty),       32'd1);
        check_val("init_af",     32'(almost_full), 32'd0);
        check_val("init_hin",    32'(HeadInTime),  32'd0);
        check_val("init_hout",   32'(HeadOutTime), 32'd0);
        reset = 1'b1;
        idle(16'd99);

        // Basic release timing and early pop
        cyc(1'b1, 5'd1, 10'd10, 1'b0, 1'b0, 1'b0, 16'd100);
        idle(16'd101);
        check_val("d_hin",   32'(HeadInTime),  32'd100);
        check_val("d_hout",  32'(HeadOutTime), 32'd110);
        check_val("d_rdy0",  32'(ready_o),     32'd0);
        for (int k = 102; k < 110; k++) begin
            cyc(1'b0, '0, '0, (k == 105), 1'b0, 1'b0, 16'(k));
        end
        check_val("d_early", 32'(early_pop), 32'd1);
        check_val("d_lvl1",  32'(level),     32'd1);
        cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 16'd110);
        check_val("d_rdy1",  32'(ready_o), 32'd1);
        idle(16'd111);
        check_val("d_empty", 32'(empty), 32'd1);

        // Release time wrapping past 2^16
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 16'd65529);
        cyc(1'b1, 5'd7, 10'd20, 1'b0, 1'b0, 1'b0, 16'd65530);
        for (int k = 65531; k <= 65535; k++) idle(16'(k));
        check_val("w_hout", 32'(HeadOutTime), 32'd14);
        check_val("w_rdy0", 32'(ready_o),     32'd0);
        for (int k = 0; k < 14; k++) idle(16'(k));
        cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 16'd14);
        check_val("w_rdy1", 32'(ready_o), 32'd1);
        idle(16'd15);

        // Overflow on a fifth push, then push+pop at full
        cur_cnt = 16'd200;
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 5'(10 + k), 10'd0, 1'b0, 1'b0, 1'b0, cur_cnt);
            cur_cnt++;
        end
        idle(cur_cnt); cur_cnt++;
        check_val("o_level", 32'(level),    32'd4);
        check_val("o_full",  32'(full),     32'd1);
        check_val("o_ovf",   32'(overflow), 32'd1);
        cyc(1'b1, 5'd20, 10'd0, 1'b1, 1'b0, 1'b0, cur_cnt); cur_cnt++;
        idle(cur_cnt); cur_cnt++;
        check_val("o_lvl4",  32'(level),      32'd4);
        check_val("o_head",  32'(RAM_Addr_o), 32'd11);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, cur_cnt); cur_cnt++;
        end
        idle(cur_cnt); cur_cnt++;
        check_val("o_last", 32'(RAM_Addr_o), 32'd20);

        // Stall freezes everything; flush clears entries and flags
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 5'(k + 1), 10'd0, 1'b0, 1'b0, 1'b0, cur_cnt); cur_cnt++;
        end
        cyc(1'b1, 5'd9, 10'd0, 1'b1, 1'b1, 1'b0, cur_cnt); cur_cnt++;
        idle(cur_cnt); cur_cnt++;
        check_val("s_level", 32'(level),    32'd3);
        check_val("s_ovf",   32'(overflow), 32'd1);
        cyc(1'b1, 5'd9, 10'd0, 1'b1, 1'b0, 1'b1, cur_cnt); cur_cnt++;
        idle(cur_cnt); cur_cnt++;
        check_val("f_level", 32'(level),    32'd0);
        check_val("f_ovf",   32'(overflow), 32'd0);

        // Asynchronous reset with three entries held
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 5'(k + 4), 10'd50, 1'b0, 1'b0, 1'b0, cur_cnt); cur_cnt++;
        end
        idle(cur_cnt); cur_cnt++;
        check_val("r_level3", 32'(level), 32'd3);
        do_reset();

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 19) == 0) cur_cnt = cur_cnt + 16'($urandom_range(0, 40000));
            else                           cur_cnt = cur_cnt + 16'd1;
            if ($urandom_range(0, 799) == 0) begin
                do_reset();
            end else begin
                cyc(($urandom_range(0, 1) == 1),
                    5'($urandom),
                    ($urandom_range(0, 15) == 0) ? 10'($urandom) : 10'($urandom_range(0, 12)),
                    ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 39) == 0),
                    cur_cnt);
            end
        end
        idle(cur_cnt + 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
